// File: rtl/jimmy_p.sv
// jimmy_p: four-register core with flags, a downward stack, branches and handshaked I/O ports.
// Latency: FETCH+EXEC (2 cycles) per instruction; IN waits on in_valid; OUT takes 3 or more cycles.
// Backpressure: IN stalls in IO_WAIT until in_valid; OUT holds out_valid until out_ready.
module jimmy_p #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int NPORT = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic [AW-1:0]       code_addr,
    input  logic [DW-1:0]       code_data,
    output logic [AW-1:0]       mem_addr,
    input  logic [DW-1:0]       mem_rdata,
    output logic [DW-1:0]       mem_wdata,
    output logic                mem_we,
    input  logic [NPORT*DW-1:0] in_data,
    input  logic [NPORT-1:0]    in_valid,
    output logic [NPORT-1:0]    in_ack,
    output logic [NPORT*DW-1:0] out_data,
    output logic [NPORT-1:0]    out_valid,
    input  logic [NPORT-1:0]    out_ready,
    output logic                halted
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_IO_WAIT, S_HALT} state_t;

    // Format A opcodes (bits [7:4])
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_CMP  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_LDR  = 4'h5;
    localparam logic [3:0] OP_STR  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Format B opcodes (bits [7:2])
    localparam logic [5:0] OP_MOVI = 6'b100000;
    localparam logic [5:0] OP_CMPI = 6'b100011;
    localparam logic [5:0] OP_INC  = 6'b100100;
    localparam logic [5:0] OP_DEC  = 6'b100101;
    localparam logic [5:0] OP_IN   = 6'b100110;
    localparam logic [5:0] OP_OUT  = 6'b100111;
    localparam logic [5:0] OP_PUSH = 6'b101000;
    localparam logic [5:0] OP_POP  = 6'b101001;
    localparam logic [5:0] OP_BRA  = 6'b101010;
    localparam logic [5:0] OP_BNE  = 6'b101011;
    localparam logic [5:0] OP_BHI  = 6'b101100;
    localparam logic [5:0] OP_BEQ  = 6'b101101;
    localparam logic [5:0] OP_CALL = 6'b101110;
    localparam logic [5:0] OP_RET  = 6'b101111;

    localparam logic [AW-1:0] A_ONE = AW'(1);

    state_t              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [AW-1:0]       sp_q, sp_d;
    logic [7:0]          ir_q, ir_d;
    logic [DW-1:0]       regs_q [4];
    logic [DW-1:0]       regs_d [4];
    logic                z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic [NPORT*DW-1:0] out_data_q, out_data_d;
    logic [NPORT-1:0]    out_valid_q, out_valid_d;

    logic                fmt_b;
    logic [3:0]          op_a;
    logic [5:0]          op_b;
    logic [1:0]          ra, rb;
    logic [DW-1:0]       a_val, b_val, b_opnd;
    logic [DW:0]         add_w, sub_w;
    logic [2*DW-1:0]     prod_w;
    logic                add_v, sub_v;
    logic                fetch_imm;
    logic                port_ok, sel_in_vld, sel_out_rdy;
    logic [DW-1:0]       sel_in_dat;
    logic [NPORT-1:0]    port_sel;
    logic [AW-1:0]       pc_inc, sp_inc, sp_dec;

    assign fmt_b  = (ir_q[7:6] == 2'b10);
    assign op_a   = ir_q[7:4];
    assign op_b   = ir_q[7:2];
    assign ra     = fmt_b ? ir_q[1:0] : ir_q[3:2];
    assign rb     = ir_q[1:0];
    assign pc_inc = pc_q + A_ONE;
    assign sp_inc = sp_q + A_ONE;
    assign sp_dec = sp_q - A_ONE;

    assign code_addr = pc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == S_HALT);

    // Instructions carrying an immediate word advance PC already in FETCH
    always_comb begin
        fetch_imm = 1'b0;
        if (code_data[7:6] == 2'b10) begin
            case (code_data[7:2])
                OP_MOVI, OP_CMPI, OP_BRA, OP_BNE, OP_BHI, OP_BEQ, OP_CALL: fetch_imm = 1'b1;
                default: fetch_imm = 1'b0;
            endcase
        end
    end

    // Shared adder/subtractor/multiplier; B operand is Rb, the immediate, or 1 for INC/DEC
    always_comb begin
        a_val  = regs_q[ra];
        b_val  = regs_q[rb];
        b_opnd = b_val;
        if (fmt_b) begin
            b_opnd = (op_b == OP_CMPI) ? code_data : DW'(1);
        end
        add_w  = {1'b0, a_val} + {1'b0, b_opnd};
        sub_w  = {1'b0, a_val} - {1'b0, b_opnd};
        add_v  = (a_val[DW-1] == b_opnd[DW-1]) && (add_w[DW-1] != a_val[DW-1]);
        sub_v  = (a_val[DW-1] != b_opnd[DW-1]) && (sub_w[DW-1] != a_val[DW-1]);
        prod_w = (2*DW)'(b_val) * (2*DW)'(a_val);
    end

    // Select the I/O port addressed by Ra; ports beyond NPORT are absent
    always_comb begin
        port_ok     = 1'b0;
        port_sel    = '0;
        sel_in_vld  = 1'b0;
        sel_in_dat  = '0;
        sel_out_rdy = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (int'(ra) == p) begin
                port_ok     = 1'b1;
                port_sel[p] = 1'b1;
                sel_in_vld  = in_valid[p];
                sel_in_dat  = in_data[p*DW +: DW];
                sel_out_rdy = out_ready[p];
            end
        end
    end

    // Next-state, datapath writes and memory/port strobes
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        in_ack      = '0;
        case (state_q)
            S_FETCH: begin
                ir_d    = code_data[7:0];
                state_d = S_EXEC;
                if (fetch_imm) pc_d = pc_inc;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                if (!fmt_b) begin
                    case (op_a)
                        OP_ADD: begin
                            regs_d[ra] = add_w[DW-1:0];
                            z_d = (add_w[DW-1:0] == '0); n_d = add_w[DW-1];
                            c_d = add_w[DW]; v_d = add_v;
                        end
                        OP_SUB, OP_CMP: begin
                            if (op_a == OP_SUB) regs_d[ra] = sub_w[DW-1:0];
                            z_d = (sub_w[DW-1:0] == '0); n_d = sub_w[DW-1];
                            c_d = sub_w[DW]; v_d = sub_v;
                        end
                        OP_MUL: begin
                            // Ra written last so it keeps the low half when Ra==Rb
                            regs_d[rb] = prod_w[2*DW-1:DW];
                            regs_d[ra] = prod_w[DW-1:0];
                        end
                        OP_MOV: begin
                            regs_d[ra] = b_val;
                            z_d = (b_val == '0); n_d = b_val[DW-1]; v_d = 1'b0;
                        end
                        OP_LDR: begin
                            mem_addr   = b_val[AW-1:0];
                            regs_d[ra] = mem_rdata;
                            z_d = (mem_rdata == '0); n_d = mem_rdata[DW-1]; v_d = 1'b0;
                        end
                        OP_STR: begin
                            mem_addr  = b_val[AW-1:0];
                            mem_wdata = a_val;
                            mem_we    = 1'b1;
                        end
                        OP_AND, OP_OR, OP_XOR: begin
                            logic [DW-1:0] lres;
                            lres = (op_a == OP_AND) ? (a_val & b_val) :
                                   (op_a == OP_OR)  ? (a_val | b_val) : (a_val ^ b_val);
                            regs_d[ra] = lres;
                            z_d = (lres == '0); n_d = lres[DW-1]; v_d = 1'b0;
                        end
                        OP_HALT: begin
                            state_d = S_HALT;
                            pc_d    = pc_q;
                        end
                        default: ;
                    endcase
                end else begin
                    case (op_b)
                        OP_MOVI: begin
                            regs_d[ra] = code_data;
                            z_d = (code_data == '0); n_d = code_data[DW-1]; v_d = 1'b0;
                        end
                        OP_CMPI, OP_DEC: begin
                            if (op_b == OP_DEC) regs_d[ra] = sub_w[DW-1:0];
                            else                c_d = sub_w[DW];
                            z_d = (sub_w[DW-1:0] == '0); n_d = sub_w[DW-1]; v_d = sub_v;
                        end
                        OP_INC: begin
                            regs_d[ra] = add_w[DW-1:0];
                            z_d = (add_w[DW-1:0] == '0); n_d = add_w[DW-1];
                            c_d = add_w[DW]; v_d = add_v;
                        end
                        OP_IN: begin
                            if (port_ok) begin
                                if (sel_in_vld) begin
                                    in_ack     = port_sel;
                                    regs_d[ra] = sel_in_dat;
                                end else begin
                                    state_d = S_IO_WAIT;
                                    pc_d    = pc_q;
                                end
                            end
                        end
                        OP_OUT: begin
                            if (port_ok) begin
                                for (int p = 0; p < NPORT; p++) begin
                                    if (port_sel[p]) out_data_d[p*DW +: DW] = a_val;
                                end
                                out_valid_d = out_valid_q | port_sel;
                                state_d     = S_IO_WAIT;
                                pc_d        = pc_q;
                            end
                        end
                        OP_PUSH: begin
                            mem_addr  = sp_q;
                            mem_wdata = a_val;
                            mem_we    = 1'b1;
                            sp_d      = sp_dec;
                        end
                        OP_POP: begin
                            mem_addr   = sp_inc;
                            regs_d[ra] = mem_rdata;
                            z_d = (mem_rdata == '0); n_d = mem_rdata[DW-1]; v_d = 1'b0;
                            sp_d       = sp_inc;
                        end
                        OP_BRA: pc_d = code_data[AW-1:0];
                        OP_BNE: if (!z_q) pc_d = code_data[AW-1:0];
                        OP_BHI: if (!c_q && !z_q) pc_d = code_data[AW-1:0];
                        OP_BEQ: if (z_q) pc_d = code_data[AW-1:0];
                        OP_CALL: begin
                            // PC points at the immediate, so the return address is PC+1
                            mem_addr  = sp_q;
                            mem_wdata = DW'(pc_inc);
                            mem_we    = 1'b1;
                            sp_d      = sp_dec;
                            pc_d      = code_data[AW-1:0];
                        end
                        OP_RET: begin
                            mem_addr = sp_inc;
                            pc_d     = mem_rdata[AW-1:0];
                            sp_d     = sp_inc;
                        end
                        default: ;
                    endcase
                end
            end
            S_IO_WAIT: begin
                if (op_b == OP_IN) begin
                    if (sel_in_vld) begin
                        in_ack     = port_sel;
                        regs_d[ra] = sel_in_dat;
                        pc_d       = pc_inc;
                        state_d    = S_FETCH;
                    end
                end else if (sel_out_rdy) begin
                    out_valid_d = out_valid_q & ~port_sel;
                    pc_d        = pc_inc;
                    state_d     = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    // Architectural state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            sp_q    <= '1;
            ir_q    <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            z_q <= 1'b0;
            n_q <= 1'b0;
            c_q <= 1'b0;
            v_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ir_q    <= ir_d;
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
            z_q <= z_d;
            n_q <= n_d;
            c_q <= c_d;
            v_q <= v_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_jimmy_p.sv
// tb_jimmy_p: directed programs on an 8-bit/4-port core and a 16-bit/2-port core.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: in_valid/out_ready driven by the bench per test.
module tb_jimmy_p;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 8-bit instance
    logic [7:0]  rom8 [256];
    logic [7:0]  ram8 [256];
    logic [7:0]  code_addr8, code_data8, mem_addr8, mem_rdata8, mem_wdata8;
    logic        mem_we8, halted8;
    logic [31:0] in_data8, out_data8;
    logic [3:0]  in_valid8, in_ack8, out_valid8, out_ready8;

    assign code_data8 = rom8[code_addr8];
    assign mem_rdata8 = ram8[mem_addr8];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) ram8[i] <= 8'h00;
        end else if (mem_we8) begin
            ram8[mem_addr8] <= mem_wdata8;
        end
    end

    jimmy_p #(.DW(8), .AW(8), .NPORT(4)) u8 (
        .clk(clk), .reset(reset),
        .code_addr(code_addr8), .code_data(code_data8),
        .mem_addr(mem_addr8), .mem_rdata(mem_rdata8), .mem_wdata(mem_wdata8), .mem_we(mem_we8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ack(in_ack8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
        .halted(halted8)
    );

    // 16-bit instance with two ports
    logic [15:0] rom16 [256];
    logic [7:0]  code_addr16, mem_addr16;
    logic [15:0] code_data16, mem_wdata16;
    logic [15:0] mem_rdata16 = 16'h0000;
    logic        mem_we16, halted16;
    logic [31:0] in_data16 = 32'h0;
    logic [31:0] out_data16;
    logic [1:0]  in_valid16 = 2'b00;
    logic [1:0]  out_ready16 = 2'b00;
    logic [1:0]  in_ack16, out_valid16;

    assign code_data16 = rom16[code_addr16];

    jimmy_p #(.DW(16), .AW(8), .NPORT(2)) u16 (
        .clk(clk), .reset(reset),
        .code_addr(code_addr16), .code_data(code_data16),
        .mem_addr(mem_addr16), .mem_rdata(mem_rdata16), .mem_wdata(mem_wdata16), .mem_we(mem_we16),
        .in_data(in_data16), .in_valid(in_valid16), .in_ack(in_ack16),
        .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready16),
        .halted(halted16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_rom();
        for (int i = 0; i < 256; i++) begin
            rom8[i]  = 8'h70;
            rom16[i] = 16'h0070;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        in_valid8  = '0;
        in_data8   = '0;
        out_ready8 = '0;
        tick(2);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        in_valid8  = '0;
        in_data8   = '0;
        out_ready8 = '0;

        // Reset state, then MOVI R0,0x7F; INC R0; HALT
        clr_rom();
        rom8[0] = 8'h80; rom8[1] = 8'h7F; rom8[2] = 8'h90; rom8[3] = 8'hFF;
        do_reset();
        chk("rst_pc", code_addr8, 8'h00);
        chk("rst_halted", halted8, 1'b0);
        chk("rst_mem_we", mem_we8, 1'b0);
        chk("rst_out", {out_valid8, out_data8}, 36'h0);
        chk("rst_in_ack", in_ack8, 4'h0);
        chk("rst_sp", u8.sp_q, 8'hFF);
        chk("rst_regs", {u8.regs_q[0], u8.regs_q[1], u8.regs_q[2], u8.regs_q[3]}, 32'h0);
        chk("rst_flags", {u8.z_q, u8.n_q, u8.c_q, u8.v_q}, 4'h0);
        release_reset();
        tick(4);
        chk("inc_r0", u8.regs_q[0], 8'h80);
        chk("inc_znvc", {u8.z_q, u8.n_q, u8.v_q, u8.c_q}, 4'b0110);
        chk("inc_pc", code_addr8, 8'h03);
        tick(4);
        chk("halt_flag", halted8, 1'b1);
        chk("halt_pc", code_addr8, 8'h03);
        reset = 1'b0;
        #1;
        chk("halt_async_rst", halted8, 1'b0);

        // MOVI R1,5; CMPI R1,5; BEQ 0x20; CMPI R1,3; BHI 0x30; BEQ 0x50 (not taken)
        clr_rom();
        rom8[0] = 8'h81; rom8[1] = 8'h05; rom8[2] = 8'h8D; rom8[3] = 8'h05;
        rom8[4] = 8'hB4; rom8[5] = 8'h20;
        rom8[8'h20] = 8'h8D; rom8[8'h21] = 8'h03; rom8[8'h22] = 8'hB0; rom8[8'h23] = 8'h30;
        rom8[8'h30] = 8'hB4; rom8[8'h31] = 8'h50;
        do_reset();
        release_reset();
        tick(6);
        chk("beq_taken_pc", code_addr8, 8'h20);
        chk("cmpi_eq_z", u8.z_q, 1'b1);
        tick(4);
        chk("bhi_taken_pc", code_addr8, 8'h30);
        chk("cmpi_gt_cz", {u8.c_q, u8.z_q}, 2'b00);
        tick(2);
        chk("beq_untaken_pc", code_addr8, 8'h32);

        // BRA 0x10; CALL 0x40 at 0x10; RET at 0x40
        clr_rom();
        rom8[0] = 8'hA8; rom8[1] = 8'h10;
        rom8[8'h10] = 8'hB8; rom8[8'h11] = 8'h40;
        rom8[8'h40] = 8'hBC;
        do_reset();
        release_reset();
        tick(2);
        chk("bra_pc", code_addr8, 8'h10);
        tick(2);
        chk("call_push", ram8[8'hFF], 8'h12);
        chk("call_sp", u8.sp_q, 8'hFE);
        chk("call_pc", code_addr8, 8'h40);
        tick(2);
        chk("ret_pc", code_addr8, 8'h12);
        chk("ret_sp", u8.sp_q, 8'hFF);

        // MOVI R0,0x33; MOVI R1,0x10; STR R0,[R1]; LDR R2,[R1]; PUSH R2; POP R3; SUB R1,R0
        clr_rom();
        rom8[0] = 8'h80; rom8[1] = 8'h33; rom8[2] = 8'h81; rom8[3] = 8'h10;
        rom8[4] = 8'h61; rom8[5] = 8'h59; rom8[6] = 8'hA2; rom8[7] = 8'hA7;
        rom8[8] = 8'h14; rom8[9] = 8'hFF;
        do_reset();
        release_reset();
        tick(5);
        chk("str_strobe", {mem_we8, mem_addr8, mem_wdata8}, {1'b1, 8'h10, 8'h33});
        tick(1);
        chk("str_mem", ram8[8'h10], 8'h33);
        chk("we_low_fetch", mem_we8, 1'b0);
        tick(2);
        chk("ldr_r2", u8.regs_q[2], 8'h33);
        tick(2);
        chk("push_mem_sp", {ram8[8'hFF], u8.sp_q}, {8'h33, 8'hFE});
        tick(2);
        chk("pop_r3_sp", {u8.regs_q[3], u8.sp_q}, {8'h33, 8'hFF});
        tick(2);
        chk("sub_r1", u8.regs_q[1], 8'hDD);
        chk("sub_ncvz", {u8.n_q, u8.c_q, u8.z_q, u8.v_q}, 4'b1100);
        // Reset in the EXEC cycle of STR kills the write strobe at once
        do_reset();
        release_reset();
        tick(5);
        chk("str_pre_abort_we", mem_we8, 1'b1);
        reset = 1'b0;
        #1;
        chk("str_abort_we", mem_we8, 1'b0);

        // IN R2 with in_valid held low, then data 0xA5
        clr_rom();
        rom8[0] = 8'h9A; rom8[1] = 8'hFF;
        do_reset();
        release_reset();
        tick(2);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("in_wait_pc", code_addr8, 8'h00);
            chk("in_wait_ack", in_ack8, 4'h0);
        end
        in_data8  = 32'h00A5_0000;
        in_valid8 = 4'b0100;
        #1;
        chk("in_ack_pulse", in_ack8, 4'b0100);
        tick(1);
        chk("in_r2", u8.regs_q[2], 8'hA5);
        chk("in_ack_drop", in_ack8, 4'h0);
        chk("in_done_pc", code_addr8, 8'h01);
        in_valid8 = '0;

        // MOVI R3,0x5A; OUT R3 with out_ready low, then high
        clr_rom();
        rom8[0] = 8'h83; rom8[1] = 8'h5A; rom8[2] = 8'h9F; rom8[3] = 8'hFF;
        do_reset();
        release_reset();
        tick(4);
        chk("out_offer", {out_valid8, out_data8}, {4'b1000, 32'h5A00_0000});
        tick(3);
        chk("out_hold", {out_valid8, out_data8}, {4'b1000, 32'h5A00_0000});
        chk("out_hold_pc", code_addr8, 8'h02);
        out_ready8 = 4'b1000;
        tick(1);
        chk("out_done", {out_valid8, out_data8}, {4'b0000, 32'h5A00_0000});
        chk("out_done_pc", code_addr8, 8'h03);
        out_ready8 = '0;
        // Reset while OUT waits clears the port without a clock edge
        do_reset();
        release_reset();
        tick(4);
        chk("out_offer2", out_valid8, 4'b1000);
        reset = 1'b0;
        #1;
        chk("out_async_rst", {out_valid8, out_data8}, 36'h0);
        chk("out_rst_pc", code_addr8, 8'h00);
        release_reset();
        tick(1);
        chk("resume_pc", code_addr8, 8'h01);

        // DW=16: MUL across two registers, MUL with Ra==Rb, OUT to absent port
        clr_rom();
        rom16[0] = 16'h0080; rom16[1] = 16'h0100; rom16[2] = 16'h0081; rom16[3] = 16'h0300;
        rom16[4] = 16'h0021; rom16[5] = 16'h0082; rom16[6] = 16'h0010; rom16[7] = 16'h002A;
        rom16[8] = 16'h009F; rom16[9] = 16'h00FF;
        do_reset();
        release_reset();
        tick(6);
        chk("mul16_hi_r1", u16.regs_q[1], 16'h0003);
        chk("mul16_lo_r0", u16.regs_q[0], 16'h0000);
        tick(4);
        chk("mul16_same_r2", u16.regs_q[2], 16'h0100);
        tick(2);
        chk("out_absent_pc", code_addr16, 8'h09);
        chk("out_absent_vld", out_valid16, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jimmy_p.md
JIMMY_P -- requirements
Module: jimmy_p

Interface
REQ-001 Parameters SHALL be: DW, default 8, data/register/code word width (>=8); AW, default 8, code and data address width (<=DW); NPORT, default 4, I/O port count (1..4).
REQ-002 Ports SHALL be, one per line as name / direction / width / meaning:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- code_addr  out  AW  program address, equals PC.
- code_data  in  DW  program word; opcode in [7:0].
- mem_addr  out  AW  data memory address.
- mem_rdata  in  DW  data memory read, combinational.
- mem_wdata  out  DW  data memory write data.
- mem_we  out  1  data memory write strobe.
- in_data  in  NPORT*DW  input port p at [p*DW +: DW].
- in_valid  in  NPORT  input port p has data.
- in_ack  out  NPORT  input port p consumed.
- out_data  out  NPORT*DW  registered output port values.
- out_valid  out  NPORT  output port p offering data.
- out_ready  in  NPORT  output port p accepts.
- halted  out  1  core in HALT.

Function
REQ-003 The core SHALL contain: R0..R3 (DW each); PC (AW); SP (AW); flags Z, N, C, V; and states FETCH, EXEC, IO_WAIT, HALT.
REQ-004 Format A instructions, where opcode[7:6]!=10, SHALL decode as op=[7:4], Ra=[3:2], Rb=[1:0]:
- ADD 0000, SUB 0001, MUL 0010, CMP 0011, MOV 0100, LDR 0101, STR 0110, NOP 0111.
- AND 1100, OR 1101, XOR 1110, HALT 1111.
REQ-005 Format B instructions, where [7:6]=10, SHALL decode as op=[7:2], Ra=[1:0]:
- MOVI 100000, CMPI 100011, INC 100100, DEC 100101, IN 100110, OUT 100111.
- PUSH 101000, POP 101001, BRA 101010, BNE 101011, BHI 101100, BEQ 101101, CALL 101110, RET 101111.
- Undefined codes execute as NOP.
REQ-006 In FETCH the core SHALL latch the decode and go to EXEC. For MOVI/CMPI/BRA/BNE/BHI/BEQ/CALL it SHALL also set PC<=PC+1, so the immediate word is present on code_data in EXEC.
REQ-007 Every instruction SHALL complete in EXEC (2 cycles total), except IN/OUT and HALT. On completion PC<=PC+1 unless the instruction is a taken branch, CALL or RET.
REQ-008 Arithmetic SHALL be modulo 2^DW:
- ADD/INC: C=carry-out, V=signed overflow.
- SUB/CMP/CMPI/DEC: result=A-B; C=borrow (A<B unsigned); V=signed overflow.
- DEC leaves C unchanged.
- CMP/CMPI update flags only.
- All of the above set Z and N from the result.
REQ-009 AND/OR/XOR, MOV, MOVI, LDR and POP SHALL set Z and N from the written value, with V=0 and C unchanged.
REQ-010 MUL SHALL write the 2*DW-bit unsigned product R[Rb]*R[Ra] as {R[Rb],R[Ra]}. If Ra==Rb, that register SHALL receive the low DW bits. Flags are unchanged.
REQ-011 Memory operations SHALL drive the data memory as follows:
- LDR: mem_addr=R[Rb][AW-1:0]; R[Ra]<=mem_rdata.
- STR: same address; mem_wdata=R[Ra]; mem_we=1 for exactly the EXEC cycle.
- mem_we SHALL be 0 in all other cycles.
REQ-012 Stack operations SHALL work as follows; SP wraps modulo 2^AW with no fault:
- PUSH: mem[SP]<=R[Ra]; SP<=SP-1.
- POP: mem_addr=SP+1; R[Ra]<=mem_rdata; SP<=SP+1.
- CALL: mem[SP]<=PC+1 (zero-extended; PC holds the immediate's address); SP<=SP-1; PC<=code_data[AW-1:0].
- RET: PC<=mem_rdata[AW-1:0] read at SP+1; SP<=SP+1.
REQ-013 Branches SHALL take the target from code_data[AW-1:0]:
- BRA: always taken.
- BEQ: taken if Z=1.
- BNE: taken if Z=0.
- BHI: taken if C=0 and Z=0.
- A branch not taken SHALL set PC<=PC+1.
REQ-014 IN p=Ra with p<NPORT SHALL behave as follows:
- In EXEC or IO_WAIT, if in_valid[p]=1: R[Ra]<=in_data[p], in_ack[p]=1 combinationally for that cycle only, complete.
- Otherwise go to or stay in IO_WAIT with PC frozen.
REQ-015 OUT p<NPORT SHALL behave as follows:
- EXEC: out_data[p]<=R[Ra]; out_valid[p]<=1; go to IO_WAIT.
- IO_WAIT: when out_ready[p]=1, out_valid[p]<=0, complete, go to FETCH.
- out_data[p] SHALL hold its value afterwards.
- Minimum OUT latency is 3 cycles.
REQ-016 IN/OUT with p>=NPORT SHALL execute as NOP.
REQ-017 HALT SHALL enter HALT with halted=1 and PC frozen, and remain there until reset.

Reset
REQ-018 While reset=0, asynchronously: state=FETCH; PC=0; SP all ones; R0..R3=0; Z=N=C=V=0; out_data=0; out_valid=0; in_ack=0; mem_we=0; halted=0.
REQ-019 Reset asserted mid-instruction, including IO_WAIT and HALT, SHALL abandon the instruction with no memory write. Execution SHALL resume at PC=0 on the first clk edge after release.

Verification
REQ-020 MOVI R0,0x7F; INC R0 -> R0=0x80, N=1, V=1, Z=0, C=0; total 4 cycles.
REQ-021 MOVI R1,5; CMPI R1,5; BEQ 0x20 -> PC=0x20. Then CMPI R1,3; BHI 0x30 -> PC=0x30 (C=0, Z=0).
REQ-022 CALL 0x40 located at 0x10, SP=0xFF -> mem[0xFF]=0x12, SP=0xFE, PC=0x40. A following RET -> PC=0x12, SP=0xFF.
REQ-023 IN R2 with in_valid[2]=0 for 5 cycles -> IO_WAIT, PC frozen, in_ack=0. Then in_valid[2]=1 with data 0xA5 -> R2=0xA5, in_ack[2] high exactly 1 cycle.
REQ-024 OUT R3 (R3=0x5A) with out_ready[3]=0 -> out_valid[3]=1, out_data[3]=0x5A held. Asserting reset -> out_valid=0 and out_data=0 immediately, without a clk edge; PC=0.
REQ-025 DW=16: R0=0x0100, R1=0x0300; MUL Ra=0, Rb=1 -> R1=0x0003, R0=0x0000. MUL Ra=Rb=2 with R2=0x0010 -> R2=0x0100.
